keypad_matrix_scanner: RTL and testbench

Parametrised successor to the fixed 4x4 keypad scanner. It scans a ROWS x COLS active-low switch matrix, synchronises and debounces the column inputs, and encodes one key as a linear index. Debounced press events are queued in a FIFO with a valid/ready interface to the control logic. Translating the index into digits or symbols is done downstream, not here.

---
 rtl/keypad_matrix_scanner.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - ROWS x COLS keypad scanner with debounce and event FIFO
// Optional auto-repeat of the held key is compiled in with `define KEYPAD_REPEAT_EN.
module keypad_matrix_scanner #(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SETTLE_CYCLES   = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 5,
  parameter int unsigned FIFO_DEPTH      = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY_FRAMES  = 50,
  parameter int unsigned REPEAT_PERIOD_FRAMES = 10
`endif
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [COLS-1:0]               column_i,
  output logic [ROWS-1:0]               row_o,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code_o,
  output logic                          key_valid_o,
  input  logic                          key_ready_i,
  output logic                          key_held_o,
  output logic                          overflow_o
);

  localparam int unsigned IDX_W = $clog2(ROWS*COLS);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned SW    = $clog2(SETTLE_CYCLES);
  localparam int unsigned DW    = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int unsigned DW1   = DW + 1;
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam logic [DW:0] D_FULL = DW1'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    S_RELEASED,
    S_PRESS_PEND,
    S_HELD,
    S_REL_PEND
  } state_e;

  // Column synchroniser; idle level of an open contact is high.
  logic [COLS-1:0] col_s1_q, col_s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_s1_q <= '1;
      col_s2_q <= '1;
    end else begin
      col_s1_q <= column_i;
      col_s2_q <= col_s1_q;
    end
  end

  // row_q is all ones only in the single idle cycle after reset, so scanning starts cleanly at row 0.
  logic [ROWS-1:0] row_q, row_d;
  logic [RW-1:0]   slot_q, slot_d;
  logic [SW-1:0]   set_q, set_d;
  logic            scanning, slot_last, frame_end;

  always_comb begin
    slot_d    = slot_q;
    set_d     = set_q;
    scanning  = ~&row_q;
    slot_last = scanning && (set_q == SW'(SETTLE_CYCLES - 1));
    frame_end = slot_last && (slot_q == RW'(ROWS - 1));
    if (scanning) begin
      if (slot_last) begin
        set_d  = '0;
        slot_d = (slot_q == RW'(ROWS - 1)) ? '0 : slot_q + RW'(1);
      end else begin
        set_d = set_q + SW'(1);
      end
    end
    row_d = ~(ROWS'(1) << slot_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q  <= '1;
      slot_q <= '0;
      set_q  <= '0;
    end else begin
      row_q  <= row_d;
      slot_q <= slot_d;
      set_q  <= set_d;
    end
  end

  // Lowest low column in the current slot, encoded as a linear index.
  logic             samp_hit;
  logic [IDX_W-1:0] samp_idx;

  always_comb begin
    samp_hit = 1'b0;
    samp_idx = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_s2_q[c]) begin
        samp_hit = 1'b1;
        samp_idx = IDX_W'(slot_q) * IDX_W'(COLS) + IDX_W'(c);
      end
    end
  end

  // Slots are visited in ascending order, so the first hit of a frame is its lowest index.
  logic             acc_hit_q;
  logic [IDX_W-1:0] acc_idx_q;
  logic             res_hit;
  logic [IDX_W-1:0] res_idx;

  assign res_hit = acc_hit_q | samp_hit;
  assign res_idx = acc_hit_q ? acc_idx_q : samp_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_hit_q <= 1'b0;
      acc_idx_q <= '0;
    end else if (frame_end) begin
      acc_hit_q <= 1'b0;
      acc_idx_q <= '0;
    end else if (slot_last && !acc_hit_q && samp_hit) begin
      acc_hit_q <= 1'b1;
      acc_idx_q <= samp_idx;
    end
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cand_q, cand_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [DW:0]      dcnt_inc;
  logic             hit_same;
  logic             push;
  logic [IDX_W-1:0] push_data;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY_FRAMES > REPEAT_PERIOD_FRAMES) ?
                                    REPEAT_DELAY_FRAMES : REPEAT_PERIOD_FRAMES;
  localparam int unsigned RPW = $clog2(REP_MAX + 1);
  logic [RPW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
  logic           rep_phase_q, rep_phase_d;
`endif

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    dcnt_d    = dcnt_q;
    push      = 1'b0;
    push_data = cand_q;
    dcnt_inc  = {1'b0, dcnt_q} + DW1'(1);
    hit_same  = res_hit && (res_idx == cand_q);
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    rep_inc     = rep_cnt_q + RPW'(1);
`endif
    if (frame_end) begin
      unique case (state_q)
        S_RELEASED: begin
          if (res_hit) begin
            cand_d = res_idx;
            dcnt_d = DW'(1);
            if (DEBOUNCE_FRAMES == 1) begin
              state_d   = S_HELD;
              push      = 1'b1;
              push_data = res_idx;
              dcnt_d    = '0;
            end else begin
              state_d = S_PRESS_PEND;
            end
          end
        end
        S_PRESS_PEND: begin
          if (!res_hit) begin
            state_d = S_RELEASED;
            dcnt_d  = '0;
          end else if (res_idx != cand_q) begin
            cand_d = res_idx;
            dcnt_d = DW'(1);
          end else if (dcnt_inc >= D_FULL) begin
            state_d = S_HELD;
            push    = 1'b1;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_inc[DW-1:0];
          end
        end
        S_HELD: begin
          if (!hit_same) begin
            state_d = (DEBOUNCE_FRAMES == 1) ? S_RELEASED : S_REL_PEND;
            dcnt_d  = (DEBOUNCE_FRAMES == 1) ? '0 : DW'(1);
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_inc == (rep_phase_q ? RPW'(REPEAT_PERIOD_FRAMES) : RPW'(REPEAT_DELAY_FRAMES))) begin
              push        = 1'b1;
              rep_cnt_d   = '0;
              rep_phase_d = 1'b1;
            end else begin
              rep_cnt_d = rep_inc;
            end
`endif
          end
        end
        S_REL_PEND: begin
          if (hit_same) begin
            state_d = S_HELD;
            dcnt_d  = '0;
          end else if (dcnt_inc >= D_FULL) begin
            state_d = S_RELEASED;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_inc[DW-1:0];
          end
        end
        default: state_d = S_RELEASED;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    // Repeat timing restarts from zero every time HELD is (re)entered.
    if (state_d != S_HELD) begin
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_RELEASED;
      cand_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      dcnt_q  <= dcnt_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`endif

  // Event FIFO; the extra pointer bit separates full from empty.
  logic [IDX_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW:0]      wr_ptr_q, rd_ptr_q;
  logic             ovf_q;
  logic             fifo_empty, fifo_full, pop, wr_en;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop        = !fifo_empty && key_ready_i;
  assign wr_en      = push && (!fifo_full || pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[PW-1:0]] <= push_data;
        wr_ptr_q                <= wr_ptr_q + DW1'(0) + (PW+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      end
      if (push && !wr_en) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign row_o       = row_q;
  assign key_code_o  = mem_q[rd_ptr_q[PW-1:0]];
  assign key_valid_o = !fifo_empty;
  assign key_held_o  = (state_q == S_HELD) || (state_q == S_REL_PEND);
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - directed bench with a frame-level reference model
// Honours KEYPAD_REPEAT_EN with REPEAT_DELAY_FRAMES=5, REPEAT_PERIOD_FRAMES=2.
module tb_keypad_matrix_scanner;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DEB   = 3;
  localparam int DEPTH = 4;
  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  column;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_held;
  logic        overflow;
  logic [15:0] pressed;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(4), .DEBOUNCE_FRAMES(DEB), .FIFO_DEPTH(DEPTH)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_DELAY_FRAMES(5), .REPEAT_PERIOD_FRAMES(2)
`endif
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .column_i(column), .row_o(row),
    .key_code_o(key_code), .key_valid_o(key_valid), .key_ready_i(key_ready),
    .key_held_o(key_held), .overflow_o(overflow)
  );

  // Physical matrix: a closed switch pulls its column low while its row is driven low.
  always_comb begin
    column = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row[r] && pressed[r*COLS+c]) column[c] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [15:0] k);
    for (int i = 0; i < 16; i++) if (k[i]) return i;
    return -1;
  endfunction

  // Reference model: one debounce decision per frame, FIFO as a queue.
  int  edge_n, m_st, m_cand, m_cnt, m_res;
  bit  m_ovf, m_pop, m_push;
  int  mq[$];
`ifdef KEYPAD_REPEAT_EN
  int  m_hf;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_n = 0; m_st = 0; m_cand = 0; m_cnt = 0; m_ovf = 0;
      mq.delete();
`ifdef KEYPAD_REPEAT_EN
      m_hf = 0;
`endif
    end else begin
      m_pop  = (mq.size() != 0) && key_ready;
      m_push = 0;
      edge_n++;
      if (edge_n >= 17 && (edge_n - 17) % FRAME == 0) begin
        m_res = lowest(pressed);
        case (m_st)
          0: if (m_res >= 0) begin m_st = 1; m_cand = m_res; m_cnt = 1; end
          1: begin
            if (m_res < 0) m_st = 0;
            else if (m_res != m_cand) begin m_cand = m_res; m_cnt = 1; end
            else begin
              m_cnt++;
              if (m_cnt == DEB) begin
                m_st = 2; m_push = 1;
`ifdef KEYPAD_REPEAT_EN
                m_hf = 0;
`endif
              end
            end
          end
          2: begin
            if (m_res != m_cand) begin m_st = 3; m_cnt = 1; end
`ifdef KEYPAD_REPEAT_EN
            else begin
              m_hf++;
              if (m_hf == 5 || (m_hf > 5 && (m_hf - 5) % 2 == 0)) m_push = 1;
            end
`endif
          end
          default: begin
            if (m_res == m_cand) begin
              m_st = 2;
`ifdef KEYPAD_REPEAT_EN
              m_hf = 0;
`endif
            end else begin
              m_cnt++;
              if (m_cnt == DEB) m_st = 0;
            end
          end
        endcase
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back(m_cand);
        else m_ovf = 1;
      end
    end
  end

  logic [3:0] exp_row;
  always @(negedge clk) begin
    exp_row = (edge_n == 0) ? 4'hF : ~(4'b0001 << (((edge_n - 1) / 4) % 4));
    check("row", int'(row), int'(exp_row));
    check("key_valid", int'(key_valid), int'(mq.size() != 0));
    if (mq.size() != 0) check("key_code", int'(key_code), mq[0]);
    check("key_held", int'(key_held), int'(m_st == 2 || m_st == 3));
    check("overflow", int'(overflow), int'(m_ovf));
  end

  int dut_pops = 0;
  int dut_popped[$];
  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready) begin
      dut_pops++;
      dut_popped.push_back(int'(key_code));
    end
  end

  function automatic int popped_at(input int i);
    if (i < dut_popped.size()) return dut_popped[i];
    return -1;
  endfunction

  task automatic frame(input logic [15:0] k);
    pressed = k;
    repeat (FRAME) @(posedge clk);
    #1;
  endtask

  task automatic frames(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) frame(k);
  endtask

  int p0;

  initial begin
    rst_n = 1'b0; pressed = '0; key_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_row", int'(row), 15);
    check("rst_valid", int'(key_valid), 0);
    check("rst_code", int'(key_code), 0);
    check("rst_held", int'(key_held), 0);
    check("rst_ovf", int'(overflow), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Scan order with no key pressed
    check("scan_r0", int'(row), 4'b1110);
    repeat (4) @(posedge clk); #1;
    check("scan_r1", int'(row), 4'b1101);
    repeat (4) @(posedge clk); #1;
    check("scan_r2", int'(row), 4'b1011);
    repeat (4) @(posedge clk); #1;
    check("scan_r3", int'(row), 4'b0111);
    repeat (4) @(posedge clk); #1;
    check("scan_wrap", int'(row), 4'b1110);
    check("scan_no_valid", int'(key_valid), 0);
    frame('0);

    // Single press of row 2, col 1
    key_ready = 1'b1;
    p0 = dut_pops; dut_popped.delete();
    frames(16'h0200, 2);
    check("press_early", int'(key_valid), 0);
    frame(16'h0200);
    check("press_valid", int'(key_valid), 1);
    check("press_head", int'(key_code), 9);
    check("press_held", int'(key_held), 1);
    frames(16'h0200, 7);
    frames('0, 2);
    check("rel_pend_held", int'(key_held), 1);
    frame('0);
    check("released", int'(key_held), 0);
    frame('0);
`ifdef KEYPAD_REPEAT_EN
    check("press_events", dut_pops - p0, 3);
`else
    check("press_events", dut_pops - p0, 1);
`endif
    check("press_code", popped_at(0), 9);

    // Release glitch while held must not produce a new event
    p0 = dut_pops;
    frames(16'h0400, 4);
    frame('0);
    check("glitch_held", int'(key_held), 1);
    frames(16'h0400, 3);
    frames('0, 4);
    check("glitch_events", dut_pops - p0, 1);

    // Bouncing key 6, then stable
    p0 = dut_pops; dut_popped.delete();
    for (int i = 0; i < 6; i++) frame((i % 2 == 0) ? 16'h0040 : 16'h0000);
    check("bounce_none", dut_pops - p0, 0);
    frames(16'h0040, 2);
    check("bounce_wait", int'(key_valid), 0);
    frame(16'h0040);
    check("bounce_valid", int'(key_valid), 1);
    check("bounce_code", int'(key_code), 6);
    frames('0, 4);
    check("bounce_events", dut_pops - p0, 1);

    // Keys 5 and 14 together resolve to the lower index
    dut_popped.delete();
    frames(16'h4020, 3);
    check("multi_head", int'(key_code), 5);
    frame(16'h4020);
    frames('0, 4);
    check("multi_code", popped_at(0), 5);

    // Overflow: five presses with the consumer stalled
    key_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      frames(16'(1 << k), 3);
      frames('0, 3);
      if (k == 3) check("ovf_before", int'(overflow), 0);
    end
    check("ovf_set", int'(overflow), 1);
    check("model_qsize", mq.size(), 4);
    dut_popped.delete(); p0 = dut_pops;
    key_ready = 1'b1;
    repeat (8) @(posedge clk); #1;
    check("ovf_pops", dut_pops - p0, 4);
    for (int i = 0; i < 4; i++) check("ovf_order", popped_at(i), i);
    check("ovf_empty", int'(key_valid), 0);
    check("ovf_sticky", int'(overflow), 1);

    // Reset in the middle of a press debounce
    frames(16'h0008, 2);
    repeat (5) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ovf", int'(overflow), 0);
    check("midrst_row", int'(row), 15);
    check("midrst_held", int'(key_held), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_r0", int'(row), 4'b1110);
    frames(16'h0008, 2);
    check("midrst_pend", int'(key_valid), 0);
    frame(16'h0008);
    check("midrst_valid", int'(key_valid), 1);
    frames('0, 4);

    // Long hold of key 7: acceptance frame plus 11 further held frames
    p0 = dut_pops;
    frames(16'h0080, 3);
    frames(16'h0080, 11);
    frames('0, 4);
`ifdef KEYPAD_REPEAT_EN
    check("repeat_events", dut_pops - p0, 5);
`else
    check("repeat_events", dut_pops - p0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
